ex_muldiv: RTL and testbench
============================

# ex_muldiv

Iterative multiply/divide unit in the EX stage. It consumes `operand_1`/`operand_2` produced by ID operand generation for MULT, MULTU, DIV and DIVU, and holds the pipeline via `stall_req` while it iterates. It writes the 64-bit result into the HI/LO registers it owns. One operation is in flight at a time. Fixed radix-2 latency of 32 iterations; divide-by-zero takes an early exit.

## Interface
- No parameters; data width fixed at 32 (`DATA_BUS`).
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  synchronous, active-low reset
- `flush`  in  1  pipeline flush; cancels any in-flight operation
- `start`  in  1  request; sampled only in IDLE
- `op`  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- `operand_1`  in  32  multiplicand / dividend (rs)
- `operand_2`  in  32  multiplier / divisor (rt)
- `stall_req`  out  1  combinational; hold ID/EX while high
- `done`  out  1  registered; high for exactly the DONE cycle
- `hi`  out  32  HI register (product high word / remainder)
- `lo`  out  32  LO register (product low word / quotient)

## Operation
- States: IDLE, MUL, DIV, DONE. A 6-bit iteration counter runs in MUL and DIV.
- IDLE + `start` + !`flush`:
  - Latch abs(operand) for signed ops or the raw operand for unsigned ops.
  - Latch result sign bits: quotient/product sign = s1^s2; remainder sign = s1.
  - Clear the 64-bit accumulator and set counter=0.
  - Go to MUL (op[1]=0) or DIV (op[1]=1).
- DIV with operand_2==0 goes straight to DONE. Result: lo=0xFFFFFFFF, hi=operand_1. This applies to both signedness.
- MUL: shift-add, one multiplier bit per cycle, LSB first. 64-bit unsigned accumulator.
- DIV: restoring. Each cycle: shift {rem,quot} left by 1, trial-subtract the divisor, set the quotient bit if no borrow.
- Counter==31 in MUL/DIV: the next state is DONE. The final magnitude is conditionally negated:
  - Product: 64-bit two's complement.
  - Quotient and remainder: each 32-bit, independently.
  - The result is written to hi/lo on that edge.
- DONE leads to IDLE unconditionally. `start` asserted during DONE is ignored.
- Signed DIV 0x80000000 / 0xFFFFFFFF: the natural result is lo=0x80000000, hi=0. No trap.
- `stall_req` = (IDLE && start && !flush) || state∈{MUL,DIV}. It is low in DONE so EX retires that cycle.
- `flush` in any state: next state IDLE, counter cleared, hi/lo unchanged, no `done` pulse. `flush` takes priority over `start` and over completion at counter==31.
- hi/lo change only on completion or reset. They hold between operations.

## Timing
- Reset (`rst_n`=0 at an edge): state IDLE, counter 0, hi=0, lo=0, `done`=0, `stall_req`=0 (when `start`=0). Reset mid-operation aborts it identically.
- Normal latency, with cycle 0 as the `start` cycle:
  - Cycles 0–32: `stall_req` high.
  - Cycles 1–32: state MUL/DIV.
  - Cycle 33: DONE, `done`=1, hi/lo valid.
  - Cycle 34: IDLE.
- Divide-by-zero latency: cycle 0 `start`, cycle 1 DONE with `done`=1. `stall_req` is high only in cycle 0.
- Back-to-back: the earliest next `start` acceptance is cycle 34.
- Operands are required stable only in the `start` cycle; they are ignored afterwards.

## Test plan
- Reset and idle: hold `rst_n`=0 for 2 cycles, then release with `start`=0 → hi=lo=0, `done`=0, `stall_req`=0 indefinitely.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → `stall_req` high cycles 0–32; cycle 33 `done`=1, hi=0xFFFFFFFE, lo=0x00000001.
- MULT signed multiply, both sign patterns:
  - 0xFFFFFFFD (−3) × 7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB.
  - MULT 2 × 3 → hi=0, lo=6.
- Divides:
  - DIV 0xFFFFFFF9 (−7) / 2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - DIVU 7 / 2 → lo=3, hi=1.
  - DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- DIVU 5 / 0 → `done` in cycle 1, lo=0xFFFFFFFF, hi=5, no further `stall_req`.
- Cancellation:
  - Preload hi/lo via MULTU 2×3. Start DIVU 100/7, assert `flush` in cycle 10 → cycle 11 IDLE, `stall_req`=0, no `done`, hi=0, lo=6.
  - Repeat with `rst_n`=0 in cycle 10 → hi=lo=0.
  - Repeat with `flush` in cycle 32 → no write.

Source files
------------

// File: rtl/ex_muldiv_if.sv
// ---------------------------------------------------------------------------
// ex_muldiv_if -- request/result bundle between the EX stage and the
// iterative multiply/divide unit.
//
//   flush      : pipeline flush, cancels any in-flight operation
//   start      : request, sampled only while the unit is idle
//   op         : 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   operand_1  : multiplicand / dividend (rs)
//   operand_2  : multiplier / divisor (rt)
//   stall_req  : hold ID/EX while high (combinational)
//   done       : one-cycle completion pulse (registered)
//   hi, lo     : HI/LO registers owned by the unit
//
// master = pipeline side, slave = ex_muldiv.
// ---------------------------------------------------------------------------
interface ex_muldiv_if;
    logic        flush;
    logic        start;
    logic [1:0]  op;
    logic [31:0] operand_1;
    logic [31:0] operand_2;
    logic        stall_req;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output flush, start, op, operand_1, operand_2,
        input  stall_req, done, hi, lo
    );

    modport slave (
        input  flush, start, op, operand_1, operand_2,
        output stall_req, done, hi, lo
    );
endinterface

// File: rtl/ex_muldiv.sv
// ---------------------------------------------------------------------------
// ex_muldiv -- iterative radix-2 multiply/divide unit for the EX stage.
//
// Ports:
//   clk    : rising-edge clock
//   rst_n  : synchronous, active-low reset
//   bus    : ex_muldiv_if.slave (flush/start/op/operands in,
//            stall_req/done/hi/lo out)
//
// One operation in flight. MUL/DIV iterate 32 cycles on magnitudes, then the
// result sign is applied and HI/LO are written on the completing edge.
// Divide by zero exits straight to DONE with lo=all-ones, hi=dividend.
// ---------------------------------------------------------------------------
module ex_muldiv (
    input  logic       clk,
    input  logic       rst_n,
    ex_muldiv_if.slave bus
);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] a_q, a_d;      // multiplicand / dividend magnitude
    logic [31:0] b_q, b_d;      // multiplier / divisor magnitude
    logic [63:0] acc_q, acc_d;  // product, or {remainder, quotient}
    logic        qneg_q, qneg_d;
    logic        rneg_q, rneg_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        done_q;
    logic        stall;

    logic signed [31:0] op1_s, op2_s;
    logic               is_signed;

    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    logic [32:0] div_trial;
    logic [33:0] div_diff;
    logic [63:0] div_next;
    logic [63:0] prod_fin;

    function automatic logic [31:0] abs32(input logic signed [31:0] v);
        return v[31] ? $unsigned(-v) : $unsigned(v);
    endfunction

    function automatic logic [31:0] cneg32(input logic [31:0] v, input logic en);
        return en ? (~v + 32'd1) : v;
    endfunction

    function automatic logic [63:0] cneg64(input logic [63:0] v, input logic en);
        return en ? (~v + 64'd1) : v;
    endfunction

    assign op1_s     = bus.operand_1;
    assign op2_s     = bus.operand_2;
    assign is_signed = ~bus.op[0];

    // Shift-add: add the multiplicand into the upper half when the current
    // multiplier bit is set, then shift the whole accumulator right. After
    // 32 steps the accumulator holds the full 64-bit product.
    assign mul_sum  = {1'b0, acc_q[63:32]} + {1'b0, (b_q[0] ? a_q : 32'd0)};
    assign mul_next = {mul_sum, acc_q[31:1]};

    // Restoring divide: the next dividend bit comes from the MSB of a_q,
    // which shifts left each step. The trial value can be 33 bits wide; if
    // it overflows 32 bits it is necessarily larger than the divisor.
    assign div_trial = {acc_q[63:32], a_q[31]};
    assign div_diff  = {1'b0, div_trial} - {2'b00, b_q};
    assign div_next  = div_diff[33] ? {div_trial[31:0], acc_q[30:0], 1'b0}
                                    : {div_diff[31:0],  acc_q[30:0], 1'b1};

    assign prod_fin = cneg64(mul_next, qneg_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        stall   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.start && !bus.flush) begin
                    stall  = 1'b1;
                    a_d    = is_signed ? abs32(op1_s) : bus.operand_1;
                    b_d    = is_signed ? abs32(op2_s) : bus.operand_2;
                    qneg_d = is_signed & (op1_s[31] ^ op2_s[31]);
                    rneg_d = is_signed & op1_s[31];
                    acc_d  = 64'd0;
                    cnt_d  = 6'd0;
                    if (bus.op[1] && (bus.operand_2 == 32'd0)) begin
                        state_d = DONE;
                        hi_d    = bus.operand_1;
                        lo_d    = 32'hFFFF_FFFF;
                    end else begin
                        state_d = bus.op[1] ? DIV : MUL;
                    end
                end
            end
            MUL: begin
                stall = 1'b1;
                acc_d = mul_next;
                b_d   = b_q >> 1;
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'd31) begin
                    state_d = DONE;
                    hi_d    = prod_fin[63:32];
                    lo_d    = prod_fin[31:0];
                end
            end
            DIV: begin
                stall = 1'b1;
                acc_d = div_next;
                a_d   = a_q << 1;
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'd31) begin
                    state_d = DONE;
                    lo_d    = cneg32(div_next[31:0],  qneg_q);
                    hi_d    = cneg32(div_next[63:32], rneg_q);
                end
            end
            DONE: begin
                state_d = IDLE;
                cnt_d   = 6'd0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 6'd0;
            end
        endcase

        // Flush wins over a new start and over the completing write.
        if (bus.flush) begin
            state_d = IDLE;
            cnt_d   = 6'd0;
            hi_d    = hi_q;
            lo_d    = lo_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 6'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= (state_d == DONE);
        end
    end

    // Datapath working registers carry no reset; they are reloaded on start.
    always_ff @(posedge clk) begin
        a_q    <= a_d;
        b_q    <= b_d;
        acc_q  <= acc_d;
        qneg_q <= qneg_d;
        rneg_q <= rneg_d;
    end

    assign bus.stall_req = stall;
    assign bus.done      = done_q;
    assign bus.hi        = hi_q;
    assign bus.lo        = lo_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// ---------------------------------------------------------------------------
// tb_ex_muldiv -- directed bench for ex_muldiv with hand-computed results.
// ---------------------------------------------------------------------------
module tb_ex_muldiv;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_err;

    ex_muldiv_if bus ();

    ex_muldiv u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation starting now (caller sits just after an edge, unit
    // idle). Measures the cycle of the done pulse and the number of stall
    // cycles before it, then checks HI/LO. Returns just after the edge that
    // leaves DONE, so a following call starts back-to-back.
    task automatic do_op(input string tag, input logic [1:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input int exp_lat,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int cyc;
        int stalls;
        bit seen;
        cyc    = 0;
        stalls = 0;
        seen   = 1'b0;
        bus.start     = 1'b1;
        bus.op        = op;
        bus.operand_1 = a;
        bus.operand_2 = b;
        while (!seen && cyc <= 40) begin
            @(negedge clk);
            if (bus.done) begin
                seen = 1'b1;
                check({tag, "_stall_in_done"}, 64'(bus.stall_req), 64'd0);
            end else begin
                if (bus.stall_req) stalls++;
                step();
                bus.start     = 1'b0;
                bus.operand_1 = $urandom;
                bus.operand_2 = $urandom;
                cyc++;
            end
        end
        check({tag, "_lat"},    64'(cyc),    64'(exp_lat));
        check({tag, "_stalls"}, 64'(stalls), 64'(exp_lat));
        check({tag, "_hi"},     64'(bus.hi), 64'(exp_hi));
        check({tag, "_lo"},     64'(bus.lo), 64'(exp_lo));
        bus.start = 1'b0;
        step();
    endtask

    // Preload HI/LO with MULTU 2x3, start DIVU 100/7, then in cycle k either
    // flush (use_rst=0) or pull reset (use_rst=1). Checks the following cycle
    // and that no done pulse ever appears.
    task automatic cancel(input string tag, input bit use_rst, input int k,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int dones;
        dones = 0;
        do_op({tag, "_pre"}, 2'b01, 32'd2, 32'd3, 33, 32'd0, 32'd6);
        bus.start     = 1'b1;
        bus.op        = 2'b11;
        bus.operand_1 = 32'd100;
        bus.operand_2 = 32'd7;
        for (int c = 0; c < k; c++) begin
            @(negedge clk);
            if (bus.done) dones++;
            step();
            bus.start = 1'b0;
        end
        if (use_rst) rst_n = 1'b0;
        else         bus.flush = 1'b1;
        @(negedge clk);
        if (bus.done) dones++;
        step();
        rst_n     = 1'b1;
        bus.flush = 1'b0;
        @(negedge clk);
        check({tag, "_stall"}, 64'(bus.stall_req), 64'd0);
        check({tag, "_hi"},    64'(bus.hi),        64'(exp_hi));
        check({tag, "_lo"},    64'(bus.lo),        64'(exp_lo));
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (bus.done || bus.stall_req) dones++;
        end
        check({tag, "_no_done"}, 64'(dones), 64'd0);
        check({tag, "_hi_hold"}, 64'(bus.hi), 64'(exp_hi));
        step();
    endtask

    initial begin
        int bad;
        n_checks      = 0;
        n_err         = 0;
        rst_n         = 1'b0;
        bus.flush     = 1'b0;
        bus.start     = 1'b0;
        bus.op        = 2'b00;
        bus.operand_1 = 32'd0;
        bus.operand_2 = 32'd0;

        // Reset and idle
        step();
        step();
        rst_n = 1'b1;
        bad = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (bus.done || bus.stall_req || bus.hi != 32'd0 || bus.lo != 32'd0) bad++;
        end
        check("reset_idle", 64'(bad), 64'd0);
        check("reset_hi", 64'(bus.hi), 64'd0);
        check("reset_lo", 64'(bus.lo), 64'd0);
        step();

        // Multiplies and divides, issued back-to-back
        do_op("multu_ff",   2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 32'hFFFF_FFFE, 32'h0000_0001);
        do_op("mult_m3x7",  2'b00, 32'hFFFF_FFFD, 32'd7,         33, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        do_op("mult_2x3",   2'b00, 32'd2,         32'd3,         33, 32'd0,         32'd6);
        do_op("mult_m7xm3", 2'b00, 32'hFFFF_FFF9, 32'hFFFF_FFFD, 33, 32'd0,         32'd21);
        do_op("div_m7_2",   2'b10, 32'hFFFF_FFF9, 32'd2,         33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        do_op("div_7_m2",   2'b10, 32'd7,         32'hFFFF_FFFE, 33, 32'd1,         32'hFFFF_FFFD);
        do_op("divu_7_2",   2'b11, 32'd7,         32'd2,         33, 32'd1,         32'd3);
        do_op("div_min_m1", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'd0,         32'h8000_0000);
        do_op("divu_5_0",   2'b11, 32'd5,         32'd0,         1,  32'd5,         32'hFFFF_FFFF);

        // No stall after the divide-by-zero completes
        bad = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (bus.stall_req || bus.done) bad++;
        end
        check("divz_quiet", 64'(bad), 64'd0);
        step();

        // Flush takes priority over start in IDLE
        bus.start     = 1'b1;
        bus.flush     = 1'b1;
        bus.op        = 2'b01;
        bus.operand_1 = 32'd9;
        bus.operand_2 = 32'd9;
        @(negedge clk);
        check("flush_start_stall", 64'(bus.stall_req), 64'd0);
        step();
        bus.start = 1'b0;
        bus.flush = 1'b0;
        @(negedge clk);
        check("flush_start_idle", 64'(bus.stall_req), 64'd0);
        step();

        // Cancellation
        cancel("flush_c10", 1'b0, 10, 32'd0, 32'd6);
        cancel("rst_c10",   1'b1, 10, 32'd0, 32'd0);
        cancel("flush_c32", 1'b0, 32, 32'd0, 32'd6);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule
